// File: rtl/param_regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
package param_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DATA_W_DEF   = 10;
    localparam int DEPTH_DEF    = 8;
    localparam int WR_LIMIT_DEF = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks a pointer over every register, one per cycle, then
// raises a single-cycle done pulse before returning to idle.
module regfile_clear_fsm
    import param_regfile_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_sweep_en,
    output logic [ADDR_W-1:0] o_sweep_ptr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = DONE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            DONE: begin
                // A request still held here is honoured only once back in IDLE.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_sweep_en  = (r_state == SWEEP);
    assign o_clr_busy  = (r_state == SWEEP);
    assign o_clr_done  = (r_state == DONE);
    assign o_sweep_ptr = r_ptr;

endmodule

// File: rtl/param_register_file.sv
// Register file with a range-limited software port, an unrestricted hardware
// status port, two combinational read ports and a sequential clear engine.
module param_register_file
    import param_regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int WR_LIMIT = WR_LIMIT_DEF,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              hw_we,
    input  logic [ADDR_W-1:0] hw_addr,
    input  logic [DATA_W-1:0] hw_data,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_err
);

    localparam logic [ADDR_W:0] SW_LIMIT = (ADDR_W + 1)'(WR_LIMIT);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_err;
    logic              w_sweep_en;
    logic [ADDR_W-1:0] w_sweep_ptr;
    logic              w_sw_in_range;
    logic              w_hw_commit;
    logic              w_sw_commit;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr_req   (clr_req),
        .o_clr_busy  (clr_busy),
        .o_clr_done  (clr_done),
        .o_sweep_en  (w_sweep_en),
        .o_sweep_ptr (w_sweep_ptr)
    );

    // The hw port wins a same-address collision, so the sw write is refused.
    assign w_sw_in_range = ({1'b0, waddr} < SW_LIMIT);
    assign w_hw_commit   = hw_we & ~w_sweep_en;
    assign w_sw_commit   = we & w_sw_in_range & ~w_sweep_en
                         & ~(hw_we & (hw_addr == waddr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_en) begin
            r_mem[w_sweep_ptr] <= '0;
        end else begin
            if (w_hw_commit) begin
                r_mem[hw_addr] <= hw_data;
            end
            if (w_sw_commit) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= we & ~w_sw_commit;
        end
    end

    assign wr_err = r_wr_err;

    // Commit signals are already masked during a sweep, so no bypass then.
    always_comb begin
        rdata1 = r_mem[raddr1];
        if ((BYPASS != 0) && w_hw_commit && (hw_addr == raddr1)) begin
            rdata1 = hw_data;
        end else if ((BYPASS != 0) && w_sw_commit && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = r_mem[raddr2];
        if ((BYPASS != 0) && w_hw_commit && (hw_addr == raddr2)) begin
            rdata2 = hw_data;
        end else if ((BYPASS != 0) && w_sw_commit && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed scenarios plus randomized traffic,
// checked every cycle against an array-and-counter model of the file.
module tb_param_register_file;

    localparam int DW  = 10;
    localparam int DEP = 8;
    localparam int WL  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we, hw_we, clr_req;
    logic [2:0]    waddr, hw_addr, raddr1, raddr2;
    logic [DW-1:0] wdata, hw_data;
    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          busy_b, done_b, err_b, busy_n, done_n, err_n;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: plain array, sweep index (-1 when not sweeping), done/err flags.
    int mem_m   [DEP];
    int mem_nxt [DEP];
    int sweep_m, sweep_nxt;
    bit done_m, done_nxt, err_m, err_nxt, have_nxt;

    always #5 clk = ~clk;

    param_register_file #(.DATA_W(DW), .DEPTH(DEP), .WR_LIMIT(WL), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b), .wr_err(err_b)
    );

    param_register_file #(.DATA_W(DW), .DEPTH(DEP), .WR_LIMIT(WL), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .clr_req(clr_req), .clr_busy(busy_n), .clr_done(done_n), .wr_err(err_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit sw_ok();
        return we && (int'(waddr) < WL) && (sweep_m < 0) && !(hw_we && hw_addr == waddr);
    endfunction

    function automatic int exp_read(input int ra, input bit byp);
        if (byp && sweep_m < 0) begin
            if (hw_we && int'(hw_addr) == ra) return int'(hw_data);
            if (sw_ok() && int'(waddr) == ra) return int'(wdata);
        end
        return mem_m[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) mem_m[i] = 0;
        sweep_m  = -1;
        done_m   = 1'b0;
        err_m    = 1'b0;
        have_nxt = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata1_byp", rd1_b, exp_read(int'(raddr1), 1'b1));
            chk("rdata2_byp", rd2_b, exp_read(int'(raddr2), 1'b1));
            chk("rdata1_nob", rd1_n, exp_read(int'(raddr1), 1'b0));
            chk("rdata2_nob", rd2_n, exp_read(int'(raddr2), 1'b0));
            chk("clr_busy", busy_b, (sweep_m >= 0));
            chk("clr_done", done_b, done_m);
            chk("wr_err", err_b, err_m);
            chk("ctrl_nob", {busy_n, done_n, err_n}, {busy_b, done_b, err_b});
        end
        for (int i = 0; i < DEP; i++) mem_nxt[i] = mem_m[i];
        done_nxt = 1'b0;
        if (sweep_m >= 0) begin
            mem_nxt[sweep_m] = 0;
            if (sweep_m == DEP - 1) begin
                sweep_nxt = -1;
                done_nxt  = 1'b1;
            end else begin
                sweep_nxt = sweep_m + 1;
            end
        end else if (done_m) begin
            sweep_nxt = -1;
        end else begin
            sweep_nxt = clr_req ? 0 : -1;
        end
        if (sweep_m < 0) begin
            if (hw_we) mem_nxt[hw_addr] = int'(hw_data);
            if (sw_ok()) mem_nxt[waddr] = int'(wdata);
        end
        err_nxt  = we && !sw_ok();
        have_nxt = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else if (have_nxt) begin
            for (int i = 0; i < DEP; i++) mem_m[i] = mem_nxt[i];
            sweep_m  = sweep_nxt;
            done_m   = done_nxt;
            err_m    = err_nxt;
            have_nxt = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we = 1'b0; hw_we = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        int nb, nd;
        model_reset();
        idle_in();
        waddr = '0; wdata = '0; hw_addr = '0; hw_data = '0; raddr1 = '0; raddr2 = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("reset_outs", {rd1_b, rd2_b, busy_b, done_b, err_b}, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Write, read back, then asynchronous reset mid-cycle
        cyc(); we = 1'b1; waddr = 3'd2; wdata = 10'h155;
        cyc(); we = 1'b0; raddr1 = 3'd2;
        #2 chk("readback_a2", rd1_n, 10'h155);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_rd", rd1_b, 0);
        chk("async_rst_rd_nob", rd1_n, 0);
        chk("async_rst_ctrl", {busy_b, done_b, err_b}, 0);
        cyc(); cyc(); rst_n = 1'b1;

        // Protected address
        cyc(); we = 1'b1; waddr = 3'd5; wdata = 10'h3FF; raddr1 = 3'd5;
        #2 chk("prot_no_bypass", rd1_b, 0);
        cyc(); we = 1'b0;
        #2 chk("prot_err", err_b, 1);
        chk("prot_unchanged", rd1_n, 0);
        chk("model_pin_a5", mem_m[5], 0);
        cyc();
        #2 chk("prot_err_single", err_b, 0);

        // hw/sw same-address collision
        cyc(); hw_we = 1'b1; hw_addr = 3'd1; hw_data = 10'h0AA;
        we = 1'b1; waddr = 3'd1; wdata = 10'h055; raddr1 = 3'd1;
        #2 chk("collide_bypass", rd1_b, 10'h0AA);
        chk("collide_nob_old", rd1_n, 0);
        cyc(); idle_in();
        #2 chk("collide_err", err_b, 1);
        chk("collide_stored", rd1_n, 10'h0AA);
        chk("model_pin_a1", mem_m[1], 10'h0AA);

        // Bypass versus no bypass on a software write
        cyc(); we = 1'b1; waddr = 3'd0; wdata = 10'h011;
        cyc(); wdata = 10'h123; raddr1 = 3'd0;
        #2 chk("nob_old_value", rd1_n, 10'h011);
        chk("byp_new_value", rd1_b, 10'h123);
        cyc(); we = 1'b0;
        #2 chk("nob_next_cycle", rd1_n, 10'h123);

        // Fill every register through the hw port, then sweep
        for (int i = 0; i < DEP; i++) begin
            cyc(); hw_we = 1'b1; hw_addr = 3'(i); hw_data = 10'(i * 16 + 5);
        end
        cyc(); hw_we = 1'b0; clr_req = 1'b1;
        cyc(); clr_req = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 16; c++) begin
            #2;
            if (busy_n) begin
                raddr1 = 3'(nb);
                raddr2 = 3'(nb - 1);
                #1 chk("sweep_pending", rd1_n, 10'(nb * 16 + 5));
                if (nb > 0) chk("sweep_cleared", rd2_n, 0);
                nb++;
            end
            if (done_n) nd++;
            cyc();
        end
        chk("busy_cycles", nb, DEP);
        chk("done_pulses", nd, 1);
        we = 1'b1; waddr = 3'd3; wdata = 10'h0F0;
        cyc(); we = 1'b0; raddr1 = 3'd3;
        #2 chk("post_clear_write", rd1_n, 10'h0F0);
        chk("post_clear_no_err", err_b, 0);

        // Write during sweep, then reset mid-sweep
        cyc(); clr_req = 1'b1;
        cyc(); clr_req = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        we = 1'b1; waddr = 3'd0; wdata = 10'h001;
        cyc(); we = 1'b0;
        #2 chk("sweep_write_err", err_b, 1);
        chk("sweep_still_busy", busy_b, 1);
        #1 rst_n = 1'b0;
        #1 chk("midsweep_rst", {busy_b, done_b, err_b}, 0);
        cyc(); cyc(); rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (done_b || busy_b) nd++;
        end
        chk("no_done_after_rst", nd, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            cyc();
            if ($urandom_range(0, 149) == 0) begin
                idle_in();
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end else begin
                we      = $urandom_range(0, 1);
                waddr   = 3'($urandom_range(0, 7));
                wdata   = 10'($urandom);
                hw_we   = ($urandom_range(0, 3) == 0);
                hw_addr = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
                hw_data = 10'($urandom);
                clr_req = ($urandom_range(0, 39) == 0);
                raddr1  = ($urandom_range(0, 1) == 0) ? waddr : 3'($urandom_range(0, 7));
                raddr2  = ($urandom_range(0, 1) == 0) ? hw_addr : 3'($urandom_range(0, 7));
            end
        end
        cyc(); idle_in();
        cyc(); cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
